// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - CLINT register offsets, bus strobe codes and tick-master FSM encoding.
package clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

    localparam int              STRB_W  = 4;
    localparam logic [STRB_W-1:0] STRB_WR = 4'hF;
    localparam logic [STRB_W-1:0] STRB_RD = 4'h0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_HI1,
        S_RD_LO,
        S_RD_HI2,
        S_CALC,
        S_WR_HI_MAX,
        S_WR_LO,
        S_WR_HI,
        S_SETTLE,
        S_ARMED,
        S_TICK,
        S_DISARM
    } state_t;

endpackage

// File: rtl/clint_bus_if.sv
// rtl/clint_bus_if.sv - single-transaction native valid/ready bus initiator.
module clint_bus_if
    import clint_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic                we,
    output logic                done,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                valid,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                ready
);

    // A request is not re-issued while done is high: the caller is still in the old state then.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= 1'b0;
            address   <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            done      <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            done <= 1'b0;
            if (valid) begin
                if (ready) begin
                    valid     <= 1'b0;
                    done      <= 1'b1;
                    rsp_rdata <= rdata;
                end
            end else if (req && !done) begin
                valid   <= 1'b1;
                address <= req_addr;
                wdata   <= we ? req_wdata : '0;
                wstrb   <= we ? STRB_WR : STRB_RD;
            end
        end
    end

endmodule

// File: rtl/clint_tick_master.sv
// rtl/clint_tick_master.sv - CLINT bus initiator producing a drift-free periodic tick for one hart.
module clint_tick_master
    import clint_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                HART_ID    = 0,
    parameter logic [ADDR_W-1:0] CLINT_BASE = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [63:0]         period,
    input  logic                mtip,
    output logic                valid,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                ready,
    output logic                busy,
    output logic                tick,
    output logic [31:0]         tick_cnt,
    output logic [15:0]         overrun_cnt
);

    localparam logic [ADDR_W-1:0] A_MTIME_LO = CLINT_BASE + ADDR_W'(MTIME_BASE);
    localparam logic [ADDR_W-1:0] A_MTIME_HI = A_MTIME_LO + ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CMP_LO   = CLINT_BASE + ADDR_W'(MTIMECMP_BASE) + ADDR_W'(8 * HART_ID);
    localparam logic [ADDR_W-1:0] A_CMP_HI   = A_CMP_LO + ADDR_W'(4);

    state_t              state, next;
    logic [63:0]         period_q, shadow;
    logic [31:0]         hi1, lo;
    logic                stop_pend, stop_any, settle_cnt, first_armed;
    logic                req, we, bus_done;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata, bus_rdata;

    assign stop_any = stop_pend | stop;
    assign busy     = (state != S_IDLE);
    assign tick     = (state == S_TICK);

    clint_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bus (
        .clk(clk), .reset(reset),
        .req(req), .req_addr(req_addr), .req_wdata(req_wdata), .we(we),
        .done(bus_done), .rsp_rdata(bus_rdata),
        .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready)
    );

    // Stop is only honoured at a bus completion or in a bus-free state, never mid-transaction.
    always_comb begin
        next      = state;
        req       = 1'b0;
        we        = 1'b1;
        req_addr  = A_CMP_HI;
        req_wdata = '1;
        unique case (state)
            S_IDLE:      if (start && period != '0) next = S_RD_HI1;
            S_RD_HI1: begin
                req = 1'b1; we = 1'b0; req_addr = A_MTIME_HI;
                if (bus_done) next = stop_any ? S_DISARM : S_RD_LO;
            end
            S_RD_LO: begin
                req = 1'b1; we = 1'b0; req_addr = A_MTIME_LO;
                if (bus_done) next = stop_any ? S_DISARM : S_RD_HI2;
            end
            S_RD_HI2: begin
                req = 1'b1; we = 1'b0; req_addr = A_MTIME_HI;
                if (bus_done) next = stop_any ? S_DISARM : (bus_rdata != hi1) ? S_RD_HI1 : S_CALC;
            end
            S_CALC:      next = stop_any ? S_DISARM : S_WR_HI_MAX;
            S_WR_HI_MAX: begin
                req = 1'b1;
                if (bus_done) next = stop_any ? S_DISARM : S_WR_LO;
            end
            S_WR_LO: begin
                req = 1'b1; req_addr = A_CMP_LO; req_wdata = shadow[31:0];
                if (bus_done) next = stop_any ? S_DISARM : S_WR_HI;
            end
            S_WR_HI: begin
                req = 1'b1; req_wdata = shadow[63:32];
                if (bus_done) next = stop_any ? S_DISARM : S_SETTLE;
            end
            S_SETTLE:    if (stop_any) next = S_DISARM; else if (settle_cnt) next = S_ARMED;
            S_ARMED: begin
                if (stop_any)  next = S_DISARM;
                else if (mtip) next = first_armed ? S_WR_HI_MAX : S_TICK;
            end
            S_TICK:      next = stop_any ? S_DISARM : S_WR_HI_MAX;
            S_DISARM: begin
                req = 1'b1;
                if (bus_done) next = S_IDLE;
            end
            default:     next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            period_q    <= '0;
            shadow      <= '1;
            hi1         <= '0;
            lo          <= '0;
            stop_pend   <= 1'b0;
            settle_cnt  <= 1'b0;
            first_armed <= 1'b0;
            tick_cnt    <= '0;
            overrun_cnt <= '0;
        end else begin
            state       <= next;
            first_armed <= (state == S_SETTLE);
            if (state == S_IDLE) stop_pend <= 1'b0;
            else if (stop)       stop_pend <= 1'b1;
            unique case (state)
                S_IDLE: if (start && period != '0) begin
                    period_q <= period;
                    tick_cnt <= '0;
                end
                S_RD_HI1: if (bus_done) hi1 <= bus_rdata;
                S_RD_LO:  if (bus_done) lo  <= bus_rdata;
                S_CALC:   shadow <= {hi1, lo} + period_q;
                S_WR_HI:  settle_cnt <= 1'b0;
                S_SETTLE: settle_cnt <= 1'b1;
                // mtip already high on the first armed cycle means the target passed during the update.
                S_ARMED: if (!stop_any && mtip && first_armed) begin
                    shadow <= shadow + period_q;
                    if (overrun_cnt != '1) overrun_cnt <= overrun_cnt + 16'd1;
                end
                S_TICK: begin
                    tick_cnt <= tick_cnt + 32'd1;
                    shadow   <= shadow + period_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_tick_master.sv
// tb/tb_clint_tick_master.sv - directed bench with a CLINT responder model for clint_tick_master.
module tb_clint_tick_master;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, mtip = 1'b0, ready = 1'b0;
    logic [63:0] period = '0;
    logic        valid, busy, tick;
    logic [31:0] address, wdata, tick_cnt;
    logic [31:0] rdata = '0;
    logic [3:0]  wstrb;
    logic [15:0] overrun_cnt;

    int          total = 0, bad = 0;
    logic [63:0] mtime = '0;
    logic [63:0] cmp = '1;
    int          lat = 1, wcnt = 0, ticks_seen = 0, roll_len = 0, roll_idx = 0;
    bit          mtip_auto = 1'b0, mtip_force = 1'b0;
    logic [31:0] roll_vals [3] = '{32'h0, 32'hFFFF_FFF0, 32'h1};
    logic [64:0] log_q [$];

    always #5 clk = ~clk;

    clint_tick_master #(.ADDR_W(32), .DATA_W(32), .HART_ID(0), .CLINT_BASE(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .period(period), .mtip(mtip),
        .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .busy(busy), .tick(tick),
        .tick_cnt(tick_cnt), .overrun_cnt(overrun_cnt)
    );

    // Responder and CLINT model: ready after `lat` cycles of valid, mtimecmp built from writes.
    always @(negedge clk) begin
        if (tick) ticks_seen++;
        if (valid) begin
            wcnt++;
            if (!ready && wcnt > lat) begin
                ready = 1'b1;
                if (wstrb == 4'hF) begin
                    log_q.push_back({1'b1, address, wdata});
                    if (address == 32'h4000)      cmp[31:0]  = wdata;
                    else if (address == 32'h4004) cmp[63:32] = wdata;
                    rdata = '0;
                end else begin
                    log_q.push_back({1'b0, address, 32'h0});
                    if (roll_idx < roll_len) begin
                        rdata = roll_vals[roll_idx];
                        roll_idx++;
                    end else begin
                        rdata = (address == 32'hBFF8) ? mtime[31:0] : mtime[63:32];
                    end
                end
            end
        end else begin
            wcnt  = 0;
            ready = 1'b0;
        end
        mtip = mtip_force || (mtip_auto && mtime >= cmp);
    end

    function automatic logic [64:0] rd(input logic [31:0] a);
        return {1'b0, a, 32'h0};
    endfunction

    function automatic logic [64:0] wr(input logic [31:0] a, input logic [31:0] d);
        return {1'b1, a, d};
    endfunction

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_log(input int n, input string tag);
        int i = 0;
        while (log_q.size() < n && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 65'(log_q.size() >= n), 65'd1);
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 65'(busy), 65'd0);
    endtask

    task automatic pulse_start(input logic [63:0] p);
        period = p;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    initial begin
        int i;
        repeat (3) @(negedge clk);
        chk("rst_valid", 65'(valid), 65'd0);
        chk("rst_busy", 65'(busy), 65'd0);
        chk("rst_tick", 65'(tick), 65'd0);
        chk("rst_tick_cnt", 65'(tick_cnt), 65'd0);
        chk("rst_overrun", 65'(overrun_cnt), 65'd0);
        reset = 1'b0;
        @(negedge clk);

        pulse_start(64'h0);
        repeat (6) @(negedge clk);
        chk("zero_busy", 65'(busy), 65'd0);
        chk("zero_bus", 65'(log_q.size()), 65'd0);

        mtime = 64'h1000; lat = 1; mtip_auto = 1'b1;
        pulse_start(64'h100);
        wait_log(6, "start_timeout");
        chk("start_rd_hi1", log_q[0], rd(32'hBFFC));
        chk("start_rd_lo", log_q[1], rd(32'hBFF8));
        chk("start_rd_hi2", log_q[2], rd(32'hBFFC));
        chk("start_wr_max", log_q[3], wr(32'h4004, 32'hFFFF_FFFF));
        chk("start_wr_lo", log_q[4], wr(32'h4000, 32'h0000_1100));
        chk("start_wr_hi", log_q[5], wr(32'h4004, 32'h0000_0000));
        repeat (10) @(negedge clk);
        chk("armed_busy", 65'(busy), 65'd1);
        chk("armed_no_tick", 65'(ticks_seen), 65'd0);

        mtime = 64'h1100;
        wait_log(9, "tick1_timeout");
        chk("tick1_lo", log_q[7], wr(32'h4000, 32'h0000_1200));
        repeat (10) @(negedge clk);
        chk("tick1_cnt", 65'(tick_cnt), 65'd1);
        chk("tick1_seen", 65'(ticks_seen), 65'd1);

        mtime = 64'h1200;
        wait_log(12, "tick2_timeout");
        chk("tick2_lo", log_q[10], wr(32'h4000, 32'h0000_1300));
        repeat (10) @(negedge clk);
        chk("tick2_cnt", 65'(tick_cnt), 65'd2);
        chk("tick2_seen", 65'(ticks_seen), 65'd2);

        mtip_force = 1'b1; mtime = 64'h1300;
        wait_log(18, "overrun_timeout");
        mtip_force = 1'b0;
        chk("tick3_lo", log_q[13], wr(32'h4000, 32'h0000_1400));
        chk("overrun_lo", log_q[16], wr(32'h4000, 32'h0000_1500));
        repeat (10) @(negedge clk);
        chk("overrun_cnt", 65'(overrun_cnt), 65'd1);
        chk("overrun_tick_cnt", 65'(tick_cnt), 65'd3);
        chk("overrun_seen", 65'(ticks_seen), 65'd3);
        chk("overrun_nbus", 65'(log_q.size()), 65'd18);

        lat = 3; mtime = 64'h1500;
        i = 0;
        while (!(valid && address == 32'h4000) && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("stop_sync", 65'(valid && address == 32'h4000), 65'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("stop_idle");
        repeat (5) @(negedge clk);
        chk("stop_max", log_q[18], wr(32'h4004, 32'hFFFF_FFFF));
        chk("stop_lo", log_q[19], wr(32'h4000, 32'h0000_1600));
        chk("stop_disarm", log_q[20], wr(32'h4004, 32'hFFFF_FFFF));
        chk("stop_nbus", 65'(log_q.size()), 65'd21);
        chk("stop_busy", 65'(busy), 65'd0);
        chk("stop_tick_cnt", 65'(tick_cnt), 65'd4);

        lat = 1; mtime = 64'h1_0000_0010; roll_len = 3;
        pulse_start(64'h100);
        wait_log(30, "roll_timeout");
        chk("roll_hi2", log_q[23], rd(32'hBFFC));
        chk("roll_restart", log_q[24], rd(32'hBFFC));
        chk("roll_wr_lo", log_q[28], wr(32'h4000, 32'h0000_0110));
        chk("roll_wr_hi", log_q[29], wr(32'h4004, 32'h0000_0001));
        chk("roll_tick_cnt", 65'(tick_cnt), 65'd0);
        repeat (10) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_log(31, "roll_stop_timeout");
        chk("roll_disarm", log_q[30], wr(32'h4004, 32'hFFFF_FFFF));
        wait_idle("roll_idle");

        lat = 3;
        pulse_start(64'h100);
        i = 0;
        while (!valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("rstmid_valid_seen", 65'(valid), 65'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_valid", 65'(valid), 65'd0);
        chk("rstmid_busy", 65'(busy), 65'd0);
        chk("rstmid_tick_cnt", 65'(tick_cnt), 65'd0);
        chk("rstmid_overrun", 65'(overrun_cnt), 65'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        stop = 1'b1;
        pulse_start(64'h100);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_beats_stop", 65'(busy), 65'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clint_tick_master.md
Name: clint_tick_master

Overview:
- Bus initiator that drives the CLINT timer on the native valid/ready bus and produces a drift-free periodic tick for one hart.
- Reads mtime, programs mtimecmp to mtime+PERIOD, waits for that hart's mtip, then re-arms at mtimecmp+PERIOD.
- Sits beside the CPU on the peripheral interconnect as a second initiator, or standalone for timer-driven subsystems.

Parameters:
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width. Only 32 is supported.
- HART_ID, 0, target hart. Selects the mtimecmp slot and the mtip bit.
- CLINT_BASE, 0, CLINT base address, added to every register offset.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin periodic operation
- stop  in  1  one-cycle pulse: disarm and return to idle
- period  in  64  tick period in mtime counts. Sampled on start.
- mtip  in  1  mtip bit of HART_ID from the CLINT
- valid  out  1  bus request
- address  out  ADDR_W  bus address
- wdata  out  DATA_W  write data
- wstrb  out  DATA_W/8  all ones = write, all zeros = read
- rdata  in  DATA_W  read data, valid while ready=1
- ready  in  1  transaction complete
- busy  out  1  not in IDLE
- tick  out  1  one-cycle pulse per period
- tick_cnt  out  32  ticks since start, wraps at 2^32
- overrun_cnt  out  16  missed periods, saturates at 16'hFFFF

Behaviour:
- Register map (offsets from CLINT_BASE):
  - mtime lo = 0xBFF8, mtime hi = 0xBFFC.
  - mtimecmp lo = 0x4000+8*HART_ID, mtimecmp hi = lo+4.
- Reset values: all outputs 0; period register 0; mtimecmp shadow all ones.
- Reset mid-transaction: valid drops at the reset edge, FSM returns to IDLE.
- Bus rules:
  - address, wdata and wstrb are registered and held stable while valid=1.
  - A transaction completes on the first cycle with valid&ready.
  - rdata is captured on that cycle.
  - valid deasserts the following cycle, giving at least one idle cycle between transactions.
- FSM states: IDLE, RD_HI1, RD_LO, RD_HI2, CALC, WR_HI_MAX, WR_LO, WR_HI, SETTLE, ARMED, TICK, DISARM.
- IDLE:
  - start with period!=0 latches period and goes to RD_HI1.
  - start with period==0 is ignored; busy stays 0.
- RD_HI1 -> RD_LO -> RD_HI2: rollover-safe 64-bit mtime read.
  - If hi2 != hi1, restart at RD_HI1.
  - Otherwise go to CALC.
- CALC (1 cycle): shadow = {hi1,lo} + period, 64-bit modulo 2^64.
- Write sequence:
  - WR_HI_MAX writes hi = 32'hFFFFFFFF, so no spurious match occurs mid-update.
  - WR_LO writes shadow[31:0].
  - WR_HI writes shadow[63:32].
  - Then go to SETTLE.
- SETTLE: wait 2 cycles to cover the CLINT's registered mtip, then go to ARMED.
- ARMED: on mtip=1, go to TICK.
- TICK (1 cycle):
  - tick=1, tick_cnt++.
  - shadow += period.
  - Go to WR_HI_MAX.
- Overrun: in the first ARMED cycle after a SETTLE, if mtip is already 1:
  - the period is treated as missed, overrun_cnt increments (saturating);
  - shadow += period, then WR_HI_MAX;
  - no tick is emitted.
- stop handling:
  - stop is latched (sticky) in any non-IDLE state.
  - It takes effect once no bus transaction is in flight.
  - DISARM writes mtimecmp hi = 32'hFFFFFFFF, then goes to IDLE.
  - stop in IDLE: no effect.
- start while busy: ignored.
- start and stop in the same cycle in IDLE: start wins; the stop is discarded.

Decomposition:
- Package clint_pkg holds:
  - offsets MSIP_BASE=16'h0, MTIMECMP_BASE=16'h4000, MTIME_BASE=16'hBFF8;
  - the bus write/read strobe constants;
  - the FSM state encoding.
- One natural sub-module, clint_bus_if: single-transaction native-bus initiator.
  - req / addr / wdata / we in; done / rdata out.
  - The main FSM issues one request per state through it.

Test Plan:
- Start: responder returns mtime=0x0000_0000_0000_1000 with a ready latency of 1 cycle, period=0x100, start pulse.
  - Required bus order: rd BFFC, rd BFF8, rd BFFC, wr 4004=FFFFFFFF, wr 4000=00001100, wr 4004=00000000.
- Rollover: mtime reads hi=0, lo=FFFFFFF0, then hi=1.
  - Required: sequence restarts, and the final cmp is computed from the re-read {1,lo} value.
- Periodic ticks: CLINT model raises mtip at cmp.
  - Required: tick pulses exactly once per match.
  - Required: second arm writes lo=00001200; tick_cnt=2 after two matches.
- Overrun: mtip held at 1 through SETTLE after re-arm.
  - Required: overrun_cnt=1, no tick, cmp advances by another 0x100.
- Stop during WR_LO with ready delayed 3 cycles.
  - Required: WR_LO completes; DISARM writes 4004=FFFFFFFF; then IDLE with busy=0.
- Reset asserted while valid=1.
  - Required: valid=0, busy=0, tick_cnt=0 next cycle.
- Zero period: start with period=0.
  - Required: no bus activity, busy stays 0.
